demux2_1_stream: RTL
====================

DEMUX2_1_STREAM -- requirements
Module: demux2_1_stream

Interface
REQ-001 Parameter WIDTH, default 64, SHALL set the data path width in bits.
REQ-002 Parameter DEPTH, default 2, SHALL set the per-output buffer depth in entries; legal values are powers of two, 2 to 16.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_data  input  WIDTH  SHALL be the word offered for routing.
REQ-006 in_sel  input  1  SHALL be the destination: 0 routes to port 0, 1 routes to port 1.
REQ-007 in_valid  input  1  SHALL indicate that in_data and in_sel are valid.
REQ-008 in_ready  output  1  SHALL indicate that the word will be accepted this cycle.
REQ-009 out0_data, out1_data  output  WIDTH each  SHALL be the head word of each port buffer.
REQ-010 out0_valid, out1_valid  output  1 each  SHALL indicate that the port buffer is non-empty.
REQ-011 out0_ready, out1_ready  input  1 each  SHALL indicate that the downstream consumer takes the head word.
REQ-012 count0, count1  output  clog2(DEPTH)+1 each  SHALL be the current occupancy of each buffer.

Function
REQ-013 A transfer SHALL occur on a rising edge when in_valid=1 and in_ready=1; the word goes only to the buffer selected by in_sel.
REQ-014 in_ready SHALL equal (count_sel < DEPTH), where count_sel is the occupancy of the buffer selected by the current in_sel. It depends combinationally on in_sel only, not on in_valid.
REQ-015 A full destination SHALL deassert in_ready even if the other buffer has space; there is no reordering or bypass to the other port.
REQ-016 Latency SHALL be one cycle: a word accepted at edge N appears on outX_data with outX_valid=1 after edge N if its buffer was empty.
REQ-017 A combinational path from in_data to outX_data SHALL NOT exist, including when the buffer is empty.
REQ-018 A pop SHALL occur on port X when outX_valid=1 and outX_ready=1; the head then advances to the next entry in FIFO order.
REQ-019 A simultaneous push and pop on the same port with 0 < count < DEPTH SHALL leave the count unchanged and preserve order.
REQ-020 When the buffer is full, in_ready for that port SHALL be 0 even if outX_ready=1 in the same cycle; space frees only on the following cycle.
REQ-021 outX_ready while outX_valid=0 SHALL have no effect, and count SHALL NOT underflow.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-023 outX_data SHALL hold a stable value while outX_valid=1 and outX_ready=0.
REQ-024 outX_data SHALL be don't-care when outX_valid=0. The implementation drives the stale head, not X.
REQ-025 The two ports SHALL operate independently; a stall on one port does not affect pops on the other.

Reset
REQ-026 Assertion of reset_n=0 SHALL immediately clear both counts and pointers, force out0_valid=out1_valid=0, and force in_ready=1, regardless of clock.
REQ-027 Reset mid-operation SHALL discard all buffered words; no word accepted before reset appears afterward.
REQ-028 Storage arrays SHALL NOT require reset; outX_data after reset is don't-care.
REQ-029 The first transfer SHALL be possible on the first rising edge after reset_n deasserts.

Structure
REQ-030 Package demux_pkg SHALL hold the default WIDTH (64), the default DEPTH (2), and an enum port_e {PORT0=0, PORT1=1} used for in_sel decoding.
REQ-031 One sub-module, demux_fifo, SHALL implement the synchronous FIFO with push, pop, full, empty, count, and head data; it is instantiated twice.
REQ-032 The top level SHALL contain only the select decode, the in_ready mux, and the push/pop enables.

Verification
REQ-033 Routing: reset, then send in_data=64'd64357 sel=0 and 64'd26000 sel=1 with both readies high -> the next cycle shows out0_data=64357 and out1_data=26000, both valid, for one cycle each.
REQ-034 Fill/stall: out0_ready=0, send three sel=0 words (1, 2, 3) -> words 1 and 2 accepted, count0=2, in_ready=0 on word 3 while sel=0, and in_ready=1 if sel switches to 1.
REQ-035 Full with pop: from count0=2, set out0_ready=1 with word 3 pending -> word 3 is not accepted that cycle, is accepted the next cycle, and out0 delivers 1, 2, 3 in order.
REQ-036 Simultaneous push/pop: count1=1 (word A), push B and pop in the same cycle -> count1 stays 1, out1_data=B next cycle.
REQ-037 Wrap-around: stream 10 sel=0 words through DEPTH=2 with random out0_ready -> all 10 emerge in order, no loss or duplication.
REQ-038 Async reset: assert reset_n low between edges with count0=2 -> out0_valid=0 and count0=0 before the next edge, and no old word appears after release.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared defaults and the destination-port encoding for the 2-way stream demux.
package demux_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_DEPTH = 2;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

endpackage

// File: rtl/demux_fifo.sv
// Synchronous FIFO with registered storage; the head word is read straight from
// the storage array, so there is never a combinational path from push data to head.
module demux_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // Guard here as well so a full push or empty pop can never corrupt the count.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/demux2_1_stream.sv
// 1-to-2 stream demultiplexer: each accepted word is queued only in the buffer
// chosen by in_sel; each output drains independently.
module demux2_1_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CW-1:0]    count0,
    output logic [CW-1:0]    count1
);

    // Handshake: a word moves on a rising edge exactly when valid and ready are
    // both high on that interface. in_ready looks only at the selected buffer and
    // never at in_valid; out_valid never depends on out_ready.

    port_e w_sel;
    logic  w_full0;
    logic  w_full1;
    logic  w_empty0;
    logic  w_empty1;
    logic  w_push0;
    logic  w_push1;
    logic  w_pop0;
    logic  w_pop1;

    assign w_sel    = port_e'(in_sel);
    assign in_ready = (w_sel == PORT1) ? !w_full1 : !w_full0;

    assign w_push0 = in_valid && in_ready && (w_sel == PORT0);
    assign w_push1 = in_valid && in_ready && (w_sel == PORT1);

    assign out0_valid = !w_empty0;
    assign out1_valid = !w_empty1;
    assign w_pop0     = out0_valid && out0_ready;
    assign w_pop1     = out1_valid && out1_ready;

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_push0),
        .i_push_data (in_data),
        .i_pop       (w_pop0),
        .o_full      (w_full0),
        .o_empty     (w_empty0),
        .o_count     (count0),
        .o_head      (out0_data)
    );

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_push1),
        .i_push_data (in_data),
        .i_pop       (w_pop1),
        .o_full      (w_full1),
        .o_empty     (w_empty1),
        .o_count     (count1),
        .o_head      (out1_data)
    );

endmodule
